// File: rtl/uart_freq_tx.sv
// uart_freq_tx: sends one 16-bit DDS frequency word as two 11-bit UART frames,
// low byte first. Frame: start(0), byte-number bit, 8 data bits LSB first, stop(1).
// Optional build macro UART_TX_SKIP_UNCHANGED_EN: frames whose byte matches the
// last word actually delivered are not sent.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle high, waiting for start
// S_START | start bit (0)
// S_SEL   | byte-number bit (0 = low byte, 1 = high byte)
// S_DATA  | 8 data bits of the selected byte, LSB first
// S_STOP  | stop bit (1)
// S_GAP   | idle bit periods between the low and high frames
// S_SKIP  | (macro builds only) both bytes unchanged, one busy cycle then done
module uart_freq_tx #(
  parameter int CLKS_PER_BIT = 521,
  parameter int GAP_BITS     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] freq_word,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Only meaningful when GAP_BITS > 0; the GAP state is never entered otherwise.
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEL,
    S_DATA,
    S_STOP,
    S_GAP
`ifdef UART_TX_SKIP_UNCHANGED_EN
    , S_SKIP
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    gap_idx_q, gap_idx_d;
  logic          byte_sel_q, byte_sel_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_last;
  logic          skip_hi;

`ifdef UART_TX_SKIP_UNCHANGED_EN
  logic        skip_hi_q, skip_hi_d;
  logic [15:0] last_sent_q, last_sent_d;
  logic        same_lo, same_hi;

  assign same_lo = (freq_word[7:0]  == last_sent_q[7:0]);
  assign same_hi = (freq_word[15:8] == last_sent_q[15:8]);
  assign skip_hi = skip_hi_q;
`else
  assign skip_hi = 1'b0;
`endif

  assign bit_last = (cnt_q == CNT_LAST);

  // Next-state, bit timing and frame sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == S_IDLE || bit_last) ? '0 : cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    gap_idx_d  = gap_idx_q;
    byte_sel_d = byte_sel_q;
    shadow_d   = shadow_q;
    done_d     = 1'b0;
`ifdef UART_TX_SKIP_UNCHANGED_EN
    skip_hi_d  = skip_hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d   = freq_word;
          byte_sel_d = 1'b0;
          bit_idx_d  = 3'd0;
          gap_idx_d  = 4'd0;
          state_d    = S_START;
`ifdef UART_TX_SKIP_UNCHANGED_EN
          skip_hi_d  = same_hi;
          if (same_lo && same_hi) state_d = S_SKIP;
          else if (same_lo)       byte_sel_d = 1'b1;
`endif
        end
      end
      S_START: if (bit_last) state_d = S_SEL;
      S_SEL: begin
        if (bit_last) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          if (!byte_sel_q && !skip_hi) begin
            byte_sel_d = 1'b1;
            gap_idx_d  = 4'd0;
            state_d    = (GAP_BITS > 0) ? S_GAP : S_START;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (bit_last) begin
          if (gap_idx_q == GAP_LAST) state_d = S_START;
          else                       gap_idx_d = gap_idx_q + 4'd1;
        end
      end
`ifdef UART_TX_SKIP_UNCHANGED_EN
      S_SKIP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the next cycle, so tx leaves a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_SEL:   tx_d = byte_sel_d;
      S_DATA:  tx_d = shadow_d[{byte_sel_d, bit_idx_d}];
      default: tx_d = 1'b1;
    endcase
  end

`ifdef UART_TX_SKIP_UNCHANGED_EN
  // Only a completed transfer counts as delivered; an abort leaves history alone.
  always_comb begin
    last_sent_d = last_sent_q;
    if (done_d) last_sent_d = shadow_q;
  end

  // Delivered-word history and high-byte skip flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sent_q <= 16'h0000;
      skip_hi_q   <= 1'b0;
    end else begin
      last_sent_q <= last_sent_d;
      skip_hi_q   <= skip_hi_d;
    end
  end
`endif

  // State, counters, shadow word and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      gap_idx_q  <= 4'd0;
      byte_sel_q <= 1'b0;
      shadow_q   <= 16'h0000;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      gap_idx_q  <= gap_idx_d;
      byte_sel_q <= byte_sel_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign tx   = tx_q;

endmodule
